// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, clock glitch filter, frame FSM, scan-code FIFO.
// Define PS2_RX_TIMEOUT_EN to abort a stalled partial frame after TIMEOUT_CYCLES clocks.
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2     = 3,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  nextdata_n,
  input  logic                  clr_err,
  output logic [7:0]            data,
  output logic                  ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  parity_err,
  output logic                  frame_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [1:0] S_IDLE = 2'd0, S_DATA = 2'd1, S_PAR = 2'd2, S_STOP = 2'd3;

  logic [1:0] clk_sync_q, dat_sync_q;
  logic       filt_q, strobe_q;
  logic [3:0] fcnt_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (clk_sync_q[1] != filt_q) begin
        if (fcnt_q == 4'(FILTER_LEN - 1)) begin
          filt_q   <= ~filt_q;
          fcnt_q   <= '0;
          strobe_q <= filt_q;
        end else begin
          fcnt_q <= fcnt_q + 4'd1;
        end
      end else begin
        fcnt_q <= '0;
      end
    end
  end

  logic [1:0] state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       push, perr_ev, ferr_ev, to_hit;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      to_cnt_q <= '0;
    else if (state_q == S_IDLE || strobe_q)
      to_cnt_q <= '0;
    else if (to_cnt_q != TW'(TIMEOUT_CYCLES))
      to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign to_hit = (state_q != S_IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES));
`else
  logic timeout_unused;
  assign timeout_unused = |TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    push    = 1'b0;
    perr_ev = 1'b0;
    ferr_ev = 1'b0;
    if (strobe_q) begin
      case (state_q)
        S_IDLE: if (!dat_sync_q[1]) begin
          state_d = S_DATA;
          bcnt_d  = '0;
        end
        S_DATA: begin
          shift_d[bcnt_q] = dat_sync_q[1];
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = S_PAR;
        end
        S_PAR: begin
          par_d   = dat_sync_q[1];
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (!dat_sync_q[1])          ferr_ev = 1'b1;
          else if (!(^{shift_q, par_q})) perr_ev = 1'b1;
          else                         push    = 1'b1;
        end
      endcase
    end else if (to_hit) begin
      state_d = S_IDLE;
      ferr_ev = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  logic [7:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wp_q, rp_q;
  logic                empty, full, pop, accept;
  logic                ovf_q, perr_q, ferr_q;

  assign empty  = (wp_q == rp_q);
  assign full   = (wp_q[DEPTH_LOG2] != rp_q[DEPTH_LOG2]) &&
                  (wp_q[DEPTH_LOG2-1:0] == rp_q[DEPTH_LOG2-1:0]);
  assign pop    = ~empty & ~nextdata_n;
  // A pop in the same cycle frees the slot the push needs.
  assign accept = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (accept) mem_q[wp_q[DEPTH_LOG2-1:0]] <= shift_q;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wp_q   <= '0;
      rp_q   <= '0;
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (accept) wp_q <= wp_q + 1'b1;
      if (pop)    rp_q <= rp_q + 1'b1;
      ovf_q  <= (ovf_q  & ~clr_err) | (push & ~accept);
      perr_q <= (perr_q & ~clr_err) | perr_ev;
      ferr_q <= (ferr_q & ~clr_err) | ferr_ev;
    end
  end

  assign data       = mem_q[rp_q[DEPTH_LOG2-1:0]];
  assign ready      = ~empty;
  assign level      = wp_q - rp_q;
  assign overflow   = ovf_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: drives PS/2 frames at the pins, checks FIFO output and flags.
module tb_ps2_rx_fifo;
  localparam int DL  = 3;
  localparam int FL  = 4;
  localparam int TO  = 1000;
  localparam int LAT = 2 + FL + 1;

  logic        clk = 1'b0, clrn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic        nextdata_n = 1'b1, clr_err = 1'b0;
  logic [7:0]  data;
  logic        ready, overflow, parity_err, frame_err;
  logic [DL:0] level;

  int         errs = 0, checks = 0;
  logic [7:0] expq[$];

  always #5 clk = ~clk;

  ps2_rx_fifo #(.DEPTH_LOG2(DL), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .clr_err(clr_err), .data(data), .ready(ready),
    .level(level), .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch, input bit pop_here);
    @(negedge clk); ps2_data = b;
    repeat (10) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b0; repeat (2) @(negedge clk);
      ps2_clk = 1'b1; repeat (8) @(negedge clk);
    end
    ps2_clk = 1'b0;
    if (pop_here) begin
      // Pop lands on the same edge as the stop-bit push.
      repeat (LAT - 1) @(posedge clk);
      #1;
      chk("coinc_head", data, expq.pop_front());
      nextdata_n = 1'b0;
      @(posedge clk); #1 nextdata_n = 1'b1;
      repeat (10) @(negedge clk);
    end else begin
      repeat (20) @(negedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                            input bit pop_last = 0, input bit glitch = 0);
    logic [10:0] f;
    f = frame(b, bad_par, bad_stop);
    for (int i = 0; i < 11; i++) send_bit(f[i], glitch && i == 4, pop_last && i == 10);
    @(negedge clk); ps2_data = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic pop_chk();
    @(negedge clk);
    if (expq.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
    else chk("data", data, expq.pop_front());
    nextdata_n = 1'b0;
    @(negedge clk); nextdata_n = 1'b1;
  endtask

  task automatic clear_errs();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [10:0] f;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_level", level, 0);
    chk("rst_flags", {overflow, parity_err, frame_err}, 0);
    clrn = 1'b1;
    repeat (3) @(negedge clk);

    // Single scan code
    expq.push_back(8'h1C);
    send_frame(8'h1C);
    chk("t1_ready", ready, 1);
    chk("t1_level", level, 1);
    pop_chk();
    chk("t1_ready_after", ready, 0);
    chk("t1_level_after", level, 0);

    // Overflow on the ninth byte
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) expq.push_back(8'(i));
      send_frame(8'(i));
    end
    chk("ovf_level", level, 8);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 8; i++) pop_chk();
    chk("ovf_drained", level, 0);
    chk("ovf_still_set", overflow, 1);
    clear_errs();
    chk("ovf_cleared", overflow, 0);

    // Parity and stop-bit errors
    send_frame(8'h1C, 1);
    chk("perr_level", level, 0);
    chk("perr_flag", parity_err, 1);
    chk("perr_no_ferr", frame_err, 0);
    send_frame(8'h1C, 0, 1);
    chk("ferr_flag", frame_err, 1);
    chk("ferr_level", level, 0);
    clear_errs();
    chk("errs_cleared", {parity_err, frame_err}, 0);

    // Short ps2_clk glitch inside a frame
    expq.push_back(8'hF0);
    send_frame(8'hF0, 0, 0, 0, 1);
    chk("glitch_level", level, 1);
    chk("glitch_flags", {overflow, parity_err, frame_err}, 0);
    pop_chk();

    // Push coinciding with pop while full
    for (int i = 0; i < 8; i++) begin
      expq.push_back(8'hA0 + 8'(i));
      send_frame(8'hA0 + 8'(i));
    end
    expq.push_back(8'hC3);
    send_frame(8'hC3, 0, 0, 1);
    chk("coinc_level", level, 8);
    chk("coinc_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) pop_chk();
    chk("coinc_drained", level, 0);

    // Asynchronous reset mid-frame
    send_frame(8'h33);
    send_frame(8'h44, 1);
    chk("pre_rst_level", level, 1);
    chk("pre_rst_perr", parity_err, 1);
    f = frame(8'h77, 0, 0);
    for (int i = 0; i < 5; i++) send_bit(f[i], 0, 0);
    @(negedge clk); clrn = 1'b0;
    #1;
    chk("arst_ready", ready, 0);
    chk("arst_level", level, 0);
    chk("arst_flags", {overflow, parity_err, frame_err}, 0);
    @(negedge clk); clrn = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    expq.push_back(8'h5A);
    send_frame(8'h5A);
    chk("post_rst_level", level, 1);
    pop_chk();
    chk("post_rst_flags", {overflow, parity_err, frame_err}, 0);

`ifdef PS2_RX_TIMEOUT_EN
    f = frame(8'h29, 0, 0);
    for (int i = 0; i < 4; i++) send_bit(f[i], 0, 0);
    repeat (TO - 50) @(negedge clk);
    chk("to_not_yet", frame_err, 0);
    repeat (100) @(negedge clk);
    chk("to_ferr", frame_err, 1);
    chk("to_level", level, 0);
    expq.push_back(8'h29);
    send_frame(8'h29);
    chk("to_recover_level", level, 1);
    pop_chk();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
